// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between WB and a buffered long-latency unit.
// Optional same-cycle bypass of idle-port long-latency results: define RF_WARB_BYPASS_EN.
module rf_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wb_valid_i,
  input  logic [4:0]               wb_addr_i,
  input  logic [31:0]              wb_data_i,
  output logic                     wb_ready_o,
  input  logic                     lu_valid_i,
  input  logic [4:0]               lu_addr_i,
  input  logic [31:0]              lu_data_i,
  output logic                     lu_ready_o,
  input  logic                     lu_issue_i,
  input  logic [4:0]               lu_issue_addr_i,
  output logic [31:0]              pending_o,
  output logic                     stall_req_o,
  output logic [$clog2(DEPTH):0]   buf_count_o,
  output logic                     rf_we_o,
  output logic [4:0]               rf_waddr_o,
  output logic [31:0]              rf_wdata_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_MAX);

  logic [4:0]       fifo_addr_q [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [31:0]      pending_q, pending_d;

  logic fifo_empty;
  logic stall;
  logic head_grant;
  logic wb_grant;
  logic byp_grant;
  logic enq;
  logic deq;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic        grant_any;
  logic [4:0]  grant_addr;
  logic [31:0] grant_data;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;

  assign fifo_empty = (count_q == '0);
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  // Forced drain is a pure decode of the registered starvation count.
  assign stall      = ~rst_i & (starve_q == STARVE_C);
  assign head_grant = ~rst_i & ~fifo_empty & (stall | ~wb_valid_i);
  assign wb_grant   = ~rst_i & ~stall & wb_valid_i;

`ifdef RF_WARB_BYPASS_EN
  assign byp_grant  = ~rst_i & ~stall & ~wb_valid_i & fifo_empty & lu_valid_i;
`else
  assign byp_grant  = 1'b0;
`endif

  assign lu_ready_o  = ~rst_i & (count_q < DEPTH_C);
  assign enq         = lu_valid_i & lu_ready_o & ~byp_grant;
  assign deq         = head_grant;
  assign wb_ready_o  = ~rst_i & ~stall;
  assign stall_req_o = stall;
  assign buf_count_o = count_q;
  assign pending_o   = pending_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_any  = 1'b0;
    grant_addr = '0;
    grant_data = '0;
    clr_mask   = '0;
    set_mask   = '0;
    if (head_grant) begin
      grant_any           = 1'b1;
      grant_addr          = head_addr;
      grant_data          = head_data;
      clr_mask[head_addr] = 1'b1;
    end else if (wb_grant) begin
      grant_any  = 1'b1;
      grant_addr = wb_addr_i;
      grant_data = wb_data_i;
    end else if (byp_grant) begin
      grant_any           = 1'b1;
      grant_addr          = lu_addr_i;
      grant_data          = lu_data_i;
      clr_mask[lu_addr_i] = 1'b1;
    end
    if (lu_issue_i && (lu_issue_addr_i != 5'd0)) begin
      set_mask[lu_issue_addr_i] = 1'b1;
    end
  end

  // r0 writes are consumed by the grant but never reach the register file.
  assign rf_we_o    = grant_any & (grant_addr != 5'd0);
  assign rf_waddr_o = grant_addr;
  assign rf_wdata_o = grant_data;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    starve_d  = starve_q;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (fifo_empty || head_grant) begin
      starve_d = '0;
    end else if (starve_q != STARVE_C) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

  // NOTE: the storage array is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_addr_q[wr_ptr_q] <= lu_addr_i;
      fifo_data_q[wr_ptr_q] <= lu_data_i;
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between the pipeline WB stage and the long-latency unit (mul/div).
- Long-latency results are held in a small FIFO until the port is free.
- Tracks outstanding long-latency destinations in a pending scoreboard used by the hazard unit.
- Bounds starvation of buffered results by forcing a one-cycle pipeline stall.

Parameters:
- DEPTH, 4, long-latency result FIFO entries (power of 2, >=2).
- STARVE_MAX, 3, consecutive denied cycles with a non-empty FIFO before a forced drain.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  WB stage presents a write.
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB write data.
- wb_ready  out  1  WB write accepted this cycle; when 0, the pipeline holds WB.
- lu_valid  in  1  long-latency result valid.
- lu_addr  in  5  result destination.
- lu_data  in  32  result data.
- lu_ready  out  1  FIFO can accept; transfer occurs when lu_valid && lu_ready.
- lu_issue  in  1  long-latency op issued this cycle.
- lu_issue_addr  in  5  destination of the issued op.
- pending  out  32  bit r = write to r outstanding from long-latency unit; bit 0 always 0.
- stall_req  out  1  forced-drain cycle; pipeline freezes WB and earlier stages.
- buf_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.

Behaviour:
- Reset (rst=1 at edge):
  - FIFO flushed, buf_count=0, pending=0, starve counter=0.
  - While rst is high: rf_we=0, wb_ready=0, lu_ready=0, stall_req=0.
  - Reset mid-operation discards buffered results without writing them.
- Write outputs:
  - rf_we/rf_waddr/rf_wdata are combinational from the grant; the register file commits at the next clk edge.
  - Write latency for WB is 0 cycles.
  - A FIFO entry enqueued at edge N is writable at the earliest in the cycle after edge N.
- Grant priority, evaluated each cycle:
  - 1. stall_req=1: FIFO head is granted; wb_ready=0.
  - 2. Else if wb_valid: WB is granted; wb_ready=1.
  - 3. Else if FIFO is non-empty: head is granted.
  - 4. Else: no write.
  - wb_ready = !stall_req whenever rst=0.
- r0 writes: a granted write with address 0 drives rf_we=0 but counts as consumed (WB acknowledged, or FIFO entry dequeued).
- FIFO:
  - lu_ready = (buf_count < DEPTH), from the registered count only; no same-cycle credit from a dequeue.
  - Simultaneous enqueue and dequeue: buf_count unchanged.
  - Read/write pointers wrap modulo DEPTH.
  - Ordering is strict FIFO.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and the head is not granted.
  - Counter clears when the head is granted or the FIFO is empty.
  - Counter saturates at STARVE_MAX.
  - stall_req = (counter == STARVE_MAX), a decode of registered state.
  - Result: at most STARVE_MAX denials, then a guaranteed drain cycle.
- Scoreboard:
  - lu_issue with addr≠0 sets pending[addr].
  - A long-latency-sourced write (granted head, or bypass) clears pending[its addr].
  - Set and clear of the same bit in one cycle: set wins.
  - The hazard unit must not issue a second long-latency op to a register whose pending bit is set, nor let WB write a pending register. The block does not check these; a later FIFO write simply overwrites.

Optional Feature:
- Macro: RF_WARB_BYPASS_EN.
- Defined: in priority step 4 (FIFO empty, no wb_valid, no stall_req), lu_valid is granted directly to the write port in the same cycle.
  - lu_ready is 1 in that cycle.
  - Nothing is enqueued; pending is cleared for lu_addr.
  - Zero-latency long-latency write.
- Undefined: all long-latency results pass through the FIFO; minimum latency is 1 cycle.

Test Plan:
- Reset dominance: rst=1 while buf_count=2, pending=0x0000_0104 → next cycle buf_count=0, pending=0, rf_we=0, and the two entries are never written.
- Simple priority: wb_valid=1 (r5, 0xAAAA_0001) and FIFO head (r7, 0x1234) in the same cycle → rf_waddr=5 this cycle; r7 written the next cycle when wb_valid=0; pending[7] 1→0.
- Starvation with wb_valid held 1 and FIFO non-empty, STARVE_MAX=3:
  - WB granted for cycles 0–2.
  - Cycle 3: stall_req=1, wb_ready=0, head written.
  - Cycle 4: WB resumes.
- Full FIFO: DEPTH=4, WB busy, 4 enqueues → buf_count=4, lu_ready=0; a fifth lu_valid is held and accepted the cycle after the first dequeue; data is written in order.
- r0 handling:
  - WB write to r0 → rf_we=0, wb_ready=1.
  - FIFO entry to r0 → rf_we=0, dequeued, buf_count decrements.
  - lu_issue to r0 → pending stays 0.
- Bypass, run with and without RF_WARB_BYPASS_EN: idle port, empty FIFO, lu_valid (r9, 0xBEEF) →
  - Defined: rf_we=1 same cycle, buf_count stays 0.
  - Undefined: enqueued, buf_count=1, written the next cycle.
